tdc_phase_stamp: RTL and testbench

Time-to-digital stamping stage directly downstream of the 32-phase DLL in the LT_T1000 receive path. The front-end latches the 32 DLL phases on each STOP edge and delivers the snapshot with a stop pulse synchronous to CKINP. This block runs the coarse counter per shot (START to timeout). It bubble-corrects the phase snapshot, encodes it to a 5-bit fine code, and queues {coarse, fine} timestamps in a small FIFO with a valid/ready output.

---
 rtl/tdc_pkg.sv | 15 +
 rtl/tdc_therm_encoder.sv | 36 +++
 rtl/tdc_phase_stamp.sv | 176 +++++++++++++++++
 tb/tb_tdc_phase_stamp.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared constants, state encoding and helpers for the TDC phase-stamping stage.
package tdc_pkg;
    localparam int unsigned NPH    = 32;
    localparam int unsigned FINE_W = 5;
    localparam logic [FINE_W-1:0] TERM_CODE = '1;

    typedef enum logic {
        IDLE,
        MEAS
    } state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/tdc_therm_encoder.sv
// Ring-smoothed thermometer-to-binary encoder for the 32-phase DLL snapshot.
module tdc_therm_encoder
    import tdc_pkg::*;
(
    input  logic [NPH-1:0]    phase_i,
    output logic [FINE_W-1:0] fine_o,
    output logic              err_o
);
    logic [NPH-1:0] m;
    logic [NPH-1:0] t;
    logic [5:0]     ntr;

    always_comb begin
        m      = '0;
        t      = '0;
        ntr    = '0;
        fine_o = '0;
        for (int unsigned i = 0; i < NPH; i++) begin
            m[i] = maj3(phase_i[(i + NPH - 1) % NPH], phase_i[i], phase_i[(i + 1) % NPH]);
        end
        // Edge is the last '1' before a '0' walking up the ring.
        for (int unsigned i = 0; i < NPH; i++) begin
            t[i] = m[i] & ~m[(i + 1) % NPH];
        end
        for (int unsigned i = 0; i < NPH; i++) begin
            if (t[i]) begin
                ntr    = ntr + 6'd1;
                fine_o = FINE_W'(i);
            end
        end
        err_o = (ntr != 6'd1);
        if (err_o) begin
            fine_o = '0;
        end
    end
endmodule

// File: rtl/tdc_phase_stamp.sv
// Per-shot coarse counter, two-stage fine-encode pipeline and timestamp FIFO.
module tdc_phase_stamp
    import tdc_pkg::*;
#(
    parameter int unsigned CW      = 16,
    parameter int unsigned N_HIT   = 4,
    parameter int unsigned MAX_CYC = 2000,
    parameter int unsigned FIFO_D  = 4
) (
    input  logic                 CKINP,
    input  logic                 RESET,
    input  logic                 dll_lock,
    input  logic                 start_pulse,
    input  logic                 stop_pulse,
    input  logic [NPH-1:0]       phase_sample,
    input  logic                 ts_ready,
    output logic                 ts_valid,
    output logic [CW+FINE_W-1:0] ts_data,
    output logic                 ts_last,
    output logic                 ts_err,
    output logic                 busy,
    output logic                 ovf_sticky,
    input  logic                 clr_ovf
);
    localparam int unsigned DW = CW + FINE_W;
    localparam int unsigned HW = $clog2(N_HIT + 1);
    localparam int unsigned AW = $clog2(FIFO_D);
    localparam logic [CW-1:0] LAST_CYC = CW'(MAX_CYC - 1);

    if (MAX_CYC > (2 ** CW) - 1) begin : g_cw_chk
        $error("MAX_CYC does not fit in CW bits without wrapping");
    end
    if (N_HIT < 1 || N_HIT > 4) begin : g_hit_chk
        $error("N_HIT must be 1..4");
    end
    if (FIFO_D < 2 || (1 << AW) != FIFO_D) begin : g_fifo_chk
        $error("FIFO_D must be a power of 2, at least 2");
    end

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          err;
    } rec_t;

    state_e          state_q, state_d;
    logic [CW-1:0]   coarse_q, coarse_d;
    logic [HW-1:0]   hit_q, hit_d;
    logic            s1_vld_q, s1_vld_d, s1_term_q, s1_term_d;
    logic            s1_err_q, s1_err_d, s1_last_q, s1_last_d;
    logic [CW-1:0]   s1_coarse_q, s1_coarse_d;
    logic [NPH-1:0]  s1_phase_q, s1_phase_d;
    logic            s2_vld_q;
    rec_t            s2_rec_q, s2_rec_d;
    logic [AW:0]     wr_q, rd_q;
    logic            ovf_q, ovf_d;
    rec_t            mem_q [FIFO_D];
    logic [FINE_W-1:0] enc_fine;
    logic            enc_err, full, pop, push, drop;
    rec_t            head;

    always_comb begin
        state_d     = state_q;
        coarse_d    = coarse_q;
        hit_d       = hit_q;
        s1_vld_d    = 1'b0;
        s1_term_d   = 1'b0;
        s1_err_d    = 1'b0;
        s1_last_d   = 1'b0;
        s1_coarse_d = s1_coarse_q;
        s1_phase_d  = s1_phase_q;
        case (state_q)
            IDLE: begin
                if (start_pulse && dll_lock) begin
                    state_d  = MEAS;
                    coarse_d = '0;
                    hit_d    = '0;
                end
            end
            MEAS: begin
                coarse_d = coarse_q + 1'b1;
                // Lock loss outranks a coincident stop; terminators ride stage 1 to keep shot order.
                if (!dll_lock) begin
                    state_d   = IDLE;
                    s1_vld_d  = 1'b1;
                    s1_term_d = 1'b1;
                    s1_err_d  = 1'b1;
                    s1_last_d = 1'b1;
                end else if (stop_pulse) begin
                    s1_vld_d    = 1'b1;
                    s1_coarse_d = coarse_q;
                    s1_phase_d  = phase_sample;
                    hit_d       = hit_q + 1'b1;
                    if (hit_q == HW'(N_HIT - 1) || coarse_q == LAST_CYC) begin
                        s1_last_d = 1'b1;
                        state_d   = IDLE;
                    end
                end else if (coarse_q == LAST_CYC) begin
                    state_d   = IDLE;
                    s1_vld_d  = 1'b1;
                    s1_term_d = 1'b1;
                    s1_last_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    tdc_therm_encoder u_enc (
        .phase_i (s1_phase_q),
        .fine_o  (enc_fine),
        .err_o   (enc_err)
    );

    always_comb begin
        s2_rec_d.data = s1_term_q ? '1 : {s1_coarse_q, enc_fine};
        s2_rec_d.last = s1_last_q;
        s2_rec_d.err  = s1_term_q ? s1_err_q : enc_err;
    end

    assign ts_valid = (wr_q != rd_q);
    assign full     = (wr_q - rd_q) == (AW + 1)'(FIFO_D);
    assign pop      = ts_valid & ts_ready;
    assign push     = s2_vld_q & (~full | pop);
    assign drop     = s2_vld_q & full & ~pop;
    assign head     = mem_q[rd_q[AW-1:0]];
    assign ts_data  = ts_valid ? head.data : '0;
    assign ts_last  = ts_valid & head.last;
    assign ts_err   = ts_valid & head.err;
    assign busy     = (state_q == MEAS);
    assign ovf_sticky = ovf_q;

    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    always_ff @(posedge CKINP) begin
        if (RESET) begin
            state_q     <= IDLE;
            coarse_q    <= '0;
            hit_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_term_q   <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_coarse_q <= '0;
            s1_phase_q  <= '0;
            s2_vld_q    <= 1'b0;
            s2_rec_q    <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            coarse_q    <= coarse_d;
            hit_q       <= hit_d;
            s1_vld_q    <= s1_vld_d;
            s1_term_q   <= s1_term_d;
            s1_err_q    <= s1_err_d;
            s1_last_q   <= s1_last_d;
            s1_coarse_q <= s1_coarse_d;
            s1_phase_q  <= s1_phase_d;
            s2_vld_q    <= s1_vld_q;
            s2_rec_q    <= s2_rec_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge CKINP) begin
        if (push) mem_q[wr_q[AW-1:0]] <= s2_rec_q;
    end
endmodule

// File: tb/tb_tdc_phase_stamp.sv
// Scoreboard bench for tdc_phase_stamp: expected records queued at stimulus, checked at output.
module tb_tdc_phase_stamp;
    import tdc_pkg::*;

    localparam int unsigned CW   = 16;
    localparam int unsigned MAXC = 2000;
    localparam int unsigned DW   = CW + FINE_W;

    logic          CKINP = 1'b0;
    logic          RESET, dll_lock, start_pulse, stop_pulse, ts_ready, clr_ovf;
    logic [31:0]   phase_sample;
    logic          ts_valid, ts_last, ts_err, busy, ovf_sticky;
    logic [DW-1:0] ts_data;

    always #5 CKINP = ~CKINP;

    tdc_phase_stamp #(.CW(CW), .N_HIT(4), .MAX_CYC(MAXC), .FIFO_D(4)) dut (
        .CKINP        (CKINP),
        .RESET        (RESET),
        .dll_lock     (dll_lock),
        .start_pulse  (start_pulse),
        .stop_pulse   (stop_pulse),
        .phase_sample (phase_sample),
        .ts_ready     (ts_ready),
        .ts_valid     (ts_valid),
        .ts_data      (ts_data),
        .ts_last      (ts_last),
        .ts_err       (ts_err),
        .busy         (busy),
        .ovf_sticky   (ovf_sticky),
        .clr_ovf      (clr_ovf)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          err;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc;
    localparam logic [DW-1:0] TERM = '1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int unsigned c, input int unsigned f);
        return {CW'(c), FINE_W'(f)};
    endfunction

    task automatic push_exp(input logic [DW-1:0] d, input logic l, input logic e);
        exp_t x;
        x.data = d; x.last = l; x.err = e;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge CKINP);
        #1;
    endtask

    task automatic do_start();
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        cyc = 0;
    endtask

    task automatic hit(input int unsigned c, input logic [31:0] ph, input logic want,
                       input int unsigned f, input logic e, input logic l);
        while (cyc < c) begin
            tick();
            cyc++;
        end
        stop_pulse   = 1'b1;
        phase_sample = ph;
        if (want) push_exp(mk(c, f), l, e);
        tick();
        cyc++;
        stop_pulse = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int unsigned bound);
        int unsigned n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, sb.size(), 0);
    endtask

    always @(negedge CKINP) begin
        exp_t e;
        if (!RESET && ts_valid && ts_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rec", {43'b0, ts_data}, 0);
            end else begin
                e = sb.pop_front();
                chk("rec_data", ts_data, e.data);
                chk("rec_last", ts_last, e.last);
                chk("rec_err",  ts_err,  e.err);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; dll_lock = 1'b1; start_pulse = 1'b0; stop_pulse = 1'b0;
        ts_ready = 1'b1; clr_ovf = 1'b0; phase_sample = '0; cyc = 0;
        tick(); tick();
        @(negedge CKINP);
        chk("rst_valid", ts_valid, 0);
        chk("rst_data",  ts_data, 0);
        chk("rst_last",  ts_last, 0);
        chk("rst_err",   ts_err, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_ovf",   ovf_sticky, 0);
        tick();
        RESET = 1'b0;
        tick();

        // Shot 1: single hit, latency, then timeout terminator.
        do_start();
        @(negedge CKINP);
        chk("busy_start", busy, 1);
        hit(10, 32'h0000FFFF, 1'b1, 15, 1'b0, 1'b0);
        @(negedge CKINP); chk("lat_c1", ts_valid, 0);
        tick(); @(negedge CKINP); chk("lat_c2", ts_valid, 0);
        tick(); @(negedge CKINP); chk("lat_c3", ts_valid, 1);
        push_exp(TERM, 1'b1, 1'b0);
        wait_idle("timeout_idle", MAXC + 100);
        drain("drain_shot1");

        // Shot 2: encoder patterns, four hits, last on the fourth.
        do_start();
        hit(3,  32'hFFFE0001, 1'b1, 0,  1'b0, 1'b0);
        hit(7,  32'h0000FDFF, 1'b1, 15, 1'b0, 1'b0);
        hit(9,  32'h00000000, 1'b1, 0,  1'b1, 1'b0);
        @(negedge CKINP);
        chk("busy_mid", busy, 1);
        hit(20, 32'h000000FF, 1'b1, 7,  1'b0, 1'b1);
        @(negedge CKINP);
        chk("busy_after4", busy, 0);
        drain("drain_shot2");

        // Stop in IDLE and start without lock are ignored.
        tick();
        stop_pulse = 1'b1; phase_sample = 32'h0000FFFF;
        tick();
        stop_pulse = 1'b0; dll_lock = 1'b0; start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0; dll_lock = 1'b1;
        @(negedge CKINP);
        chk("ign_start", busy, 0);
        repeat (6) tick();
        @(negedge CKINP);
        chk("ign_stop", ts_valid, 0);

        // Stop coincident with the last window cycle: hit with last, no terminator.
        tick();
        do_start();
        hit(MAXC - 1, 32'h0000FFFF, 1'b1, 15, 1'b0, 1'b1);
        @(negedge CKINP);
        chk("busy_edge", busy, 0);
        drain("drain_edge");
        repeat (8) tick();
        @(negedge CKINP);
        chk("no_term_edge", ts_valid, 0);

        // Overflow: six hits over two shots with the consumer stalled.
        tick();
        ts_ready = 1'b0;
        do_start();
        hit(1, 32'h0000FFFF, 1'b1, 15, 1'b0, 1'b0);
        hit(2, 32'h00000FFF, 1'b1, 11, 1'b0, 1'b0);
        hit(3, 32'h000000FF, 1'b1, 7,  1'b0, 1'b0);
        hit(4, 32'h0000000F, 1'b1, 3,  1'b0, 1'b1);
        do_start();
        hit(1, 32'h0000FFFF, 1'b0, 15, 1'b0, 1'b0);
        hit(2, 32'h0000FFFF, 1'b0, 15, 1'b0, 1'b0);
        dll_lock = 1'b0;
        tick();
        dll_lock = 1'b1;
        repeat (5) tick();
        @(negedge CKINP);
        chk("ovf_set", ovf_sticky, 1);
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", ts_valid, 1);
            chk("hold_data",  ts_data, mk(1, 15));
            chk("hold_last",  ts_last, 0);
            tick();
            @(negedge CKINP);
        end
        tick();
        ts_ready = 1'b1;
        drain("drain_ovf");
        repeat (6) tick();
        @(negedge CKINP);
        chk("ovf_drained", ts_valid, 0);
        chk("ovf_hold", ovf_sticky, 1);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        @(negedge CKINP);
        chk("ovf_clr", ovf_sticky, 0);

        // Lock loss mid-shot with a coincident stop.
        tick();
        do_start();
        hit(4, 32'h0000FFFF, 1'b1, 15, 1'b0, 1'b0);
        while (cyc < 8) begin
            tick();
            cyc++;
        end
        dll_lock = 1'b0; stop_pulse = 1'b1; phase_sample = 32'h000000FF;
        push_exp(TERM, 1'b1, 1'b1);
        tick();
        stop_pulse = 1'b0; dll_lock = 1'b1;
        @(negedge CKINP);
        chk("busy_lock", busy, 0);
        drain("drain_lock");

        // Reset mid-shot flushes FIFO and pipeline.
        tick();
        ts_ready = 1'b0;
        do_start();
        hit(2, 32'h0000FFFF, 1'b0, 15, 1'b0, 1'b0);
        repeat (3) tick();
        @(negedge CKINP);
        chk("rst_pre_valid", ts_valid, 1);
        tick();
        stop_pulse = 1'b1;
        tick();
        stop_pulse = 1'b0;
        RESET = 1'b1;
        tick();
        @(negedge CKINP);
        chk("rst_mid_valid", ts_valid, 0);
        chk("rst_mid_busy",  busy, 0);
        tick();
        RESET = 1'b0;
        ts_ready = 1'b1;
        repeat (10) tick();
        @(negedge CKINP);
        chk("rst_mid_empty", ts_valid, 0);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
